// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Owner tags identify which requester a returning read belongs to.
package dm_arb_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dm_port_arbiter.sv
// Single-port data memory shared between the CPU load/store path and the debug unit.
// Debug has fixed priority; a starvation counter forces a CPU win outside debug mode.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    owner_e           rd_own;
    logic             cpu_eligible;
    logic             starved;

    // Handshake: a requester holds req/we/addr/wdata until it sees gnt; the
    // request is consumed in the gnt cycle and at most one gnt fires per cycle.
    assign cpu_eligible = cpu_req && !debug;
    assign starved      = (starve_cnt == CNT_MAX);
    assign cpu_gnt      = !rst && cpu_eligible && (!dbg_req || starved);
    assign dbg_gnt      = !rst && dbg_req && !(cpu_eligible && starved);
    assign mem_en       = cpu_gnt || dbg_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_own     <= OWN_NONE;
        end else begin
            if (cpu_gnt || !cpu_eligible) begin
                starve_cnt <= '0;
            end else if (dbg_gnt && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (cpu_gnt && !cpu_we) begin
                rd_own <= OWN_CPU;
            end else if (dbg_gnt && !dbg_we) begin
                rd_own <= OWN_DBG;
            end else begin
                rd_own <= OWN_NONE;
            end
        end
    end

    // Gating with rst drops a read that was granted just before reset rose.
    assign cpu_rvalid = !rst && (rd_own == OWN_CPU);
    assign dbg_rvalid = !rst && (rd_own == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a synchronous RAM, an arbitration/memory model with
// a read-return queue checked every cycle, and directed scenarios with literal expectations.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int EW = 2 + DW;

    logic          clk;
    logic          rst;
    logic          debug;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // model state
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] model_mem [0:255];
    logic [EW-1:0] exp_q [$];
    int            streak;

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .debug(debug),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA5A50000 | DW'(i);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = init_word(i);
            model_mem[i] = init_word(i);
        end
        mem_rdata = '0;
        streak    = 0;
    end

    // synchronous RAM behind the arbiter
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- scoreboard / model compare ----------------
    always @(negedge clk) begin
        logic          ec, ed, cpu_elig, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [EW-1:0] ret;
        logic          exp_crv, exp_drv;

        ec = 1'b0;
        ed = 1'b0;
        cpu_elig = cpu_req && !debug;
        if (!rst) begin
            if (dbg_req && cpu_elig) begin
                if (streak >= SM) ec = 1'b1;
                else              ed = 1'b1;
            end else if (dbg_req) begin
                ed = 1'b1;
            end else if (cpu_elig) begin
                ec = 1'b1;
            end
        end

        exp_we    = ec ? cpu_we    : (ed ? dbg_we    : 1'b0);
        exp_addr  = ec ? cpu_addr  : (ed ? dbg_addr  : '0);
        exp_wdata = ec ? cpu_wdata : (ed ? dbg_wdata : '0);

        ret = '0;
        if (exp_q.size() > 0) ret = exp_q.pop_front();
        if (rst) ret = '0;
        exp_crv = (ret[EW-1 -: 2] == 2'd1);
        exp_drv = (ret[EW-1 -: 2] == 2'd2);

        chk("cpu_gnt",    cpu_gnt,    ec);
        chk("dbg_gnt",    dbg_gnt,    ed);
        chk("mem_en",     mem_en,     ec || ed);
        chk("mem_we",     mem_we,     exp_we);
        chk("mem_addr",   mem_addr,   exp_addr);
        chk("mem_wdata",  mem_wdata,  exp_wdata);
        chk("cpu_rvalid", cpu_rvalid, exp_crv);
        chk("cpu_rdata",  cpu_rdata,  exp_crv ? ret[DW-1:0] : '0);
        chk("dbg_rvalid", dbg_rvalid, exp_drv);
        chk("dbg_rdata",  dbg_rdata,  exp_drv ? ret[DW-1:0] : '0);

        if (rst) begin
            streak = 0;
            exp_q.delete();
        end else begin
            if (!cpu_elig || ec) streak = 0;
            else if (ed)         streak = streak + 1;
            if (ec || ed) begin
                if (exp_we) model_mem[exp_addr] = exp_wdata;
                else        exp_q.push_back({ec ? 2'd1 : 2'd2, model_mem[exp_addr]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_xfer(input mem_req_t r);
        logic got;
        got = 1'b0;
        cpu_req = 1'b1; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wdata;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = cpu_gnt;
        end
        chk("cpu_xfer_gnt", got, 1'b1);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic dbg_xfer(input mem_req_t r);
        logic got;
        got = 1'b0;
        dbg_req = 1'b1; dbg_we = r.we; dbg_addr = r.addr; dbg_wdata = r.wdata;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = dbg_gnt;
        end
        chk("dbg_xfer_gnt", got, 1'b1);
        step();
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        string seq;
        int    cnt;

        rst = 1'b1; debug = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21; cpu_wdata = '0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20; dbg_wdata = '0;

        // reset held two cycles with both requests up
        repeat (2) begin
            @(negedge clk);
            chk("rst_cpu_gnt", cpu_gnt, 1'b0);
            chk("rst_dbg_gnt", dbg_gnt, 1'b0);
            chk("rst_mem_en",  mem_en,  1'b0);
            chk("rst_rvalid",  cpu_rvalid | dbg_rvalid, 1'b0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dbg_first", dbg_gnt, 1'b1);
        step();
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // CPU alone: write then read back
        cpu_xfer('{1'b1, 8'h10, 32'hDEADBEEF});
        cpu_xfer('{1'b0, 8'h10, 32'h0});
        @(negedge clk);
        chk("cpu_rd_rvalid",  cpu_rvalid, 1'b1);
        chk("cpu_rd_rdata",   cpu_rdata,  32'hDEADBEEF);
        chk("cpu_rd_dbg_rv",  dbg_rvalid, 1'b0);
        step();

        // contention: both held for ten cycles
        seq = "";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h05;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq = {seq, cpu_gnt ? "C" : (dbg_gnt ? "D" : "-")};
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++;
        if (seq != "DDDDCDDDDC") begin
            errors++;
            $display("FAIL contention_seq: got %s expected DDDDCDDDDC", seq);
        end
        step();

        // debug lock: CPU request pending for 20 cycles
        debug = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h06;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_gnt) cnt++;
            step();
        end
        chk("dbg_lock_cpu_gnts", DW'(cnt), '0);
        debug = 1'b0;
        @(negedge clk);
        chk("dbg_release_gnt", cpu_gnt, 1'b1);
        step();
        cpu_req = 1'b0;
        step();

        // CPU read in flight when debug rises
        cpu_xfer('{1'b0, 8'h03, 32'h0});
        debug = 1'b1;
        @(negedge clk);
        chk("inflight_rvalid", cpu_rvalid, 1'b1);
        chk("inflight_rdata",  cpu_rdata,  32'hA5A50003);
        step();
        debug = 1'b0;
        step();

        // reset right after a debug read grant
        dbg_xfer('{1'b0, 8'h07, 32'h0});
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 32'h11112222;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h34; dbg_wdata = 32'h33334444;
        @(negedge clk);
        chk("rstmid_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rstmid_dbg_rdata",  dbg_rdata,  '0);
        chk("rstmid_gnts",       cpu_gnt | dbg_gnt, 1'b0);
        chk("rstmid_mem_addr",   mem_addr,  '0);
        chk("rstmid_mem_wdata",  mem_wdata, '0);
        step();
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        step();

        // cross-port data routing
        dbg_xfer('{1'b1, 8'h30, 32'h12345678});
        cpu_xfer('{1'b0, 8'h30, 32'h0});
        @(negedge clk);
        chk("xport_cpu_rdata", cpu_rdata, 32'h12345678);
        step();
        dbg_xfer('{1'b0, 8'h10, 32'h0});
        @(negedge clk);
        chk("xport_dbg_rdata",  dbg_rdata,  32'hDEADBEEF);
        chk("xport_cpu_rvalid", cpu_rvalid, 1'b0);
        step();

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
